// File: rtl/lockin_pkg.sv
// Shared types and constants for the lock-in demodulator.
// saturate_out clamps a 64-bit value to the 32-bit result range.
package lockin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACUM  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ACC_W        = 64;
    localparam int PROD_W       = 48;
    localparam int OUT_W        = 32;
    localparam int DRAIN_CYCLES = 2;

    localparam logic signed [ACC_W-1:0] OUT_MAX = 64'sh0000_0000_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] OUT_MIN = 64'shFFFF_FFFF_8000_0000;

    function automatic logic signed [OUT_W-1:0] saturate_out(input logic signed [ACC_W-1:0] v);
        logic signed [OUT_W-1:0] r;
        if (v > OUT_MAX) begin
            r = OUT_MAX[OUT_W-1:0];
        end else if (v < OUT_MIN) begin
            r = OUT_MIN[OUT_W-1:0];
        end else begin
            r = v[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_lockin.sv
// One multiply-accumulate lane: registered sample*reference product,
// then a wrapping 64-bit accumulator. clr_i wipes both stages.
module mac_lockin
    import lockin_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REF_W  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic signed [REF_W-1:0]  ref_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_valid_q, prod_valid_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;

    always_comb begin
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        acc_d        = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else begin
            if (en_i) begin
                prod_d       = PROD_W'(sample_i) * PROD_W'(ref_i);
                prod_valid_d = 1'b1;
            end
            if (prod_valid_q) begin
                acc_d = acc_q + ACC_W'(prod_q);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prod_q       <= '0;
            prod_valid_q <= 1'b0;
            acc_q        <= '0;
        end else begin
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
            acc_q        <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/demodulador_lockin.sv
// Coherent lock-in demodulator: X/Y integration over pts_x_ciclo*ciclos samples.
// Define LOCKIN_SAT_EN to saturate results instead of wrapping to 32 bits.
module demodulador_lockin
    import lockin_pkg::*;
#(
    parameter int SHIFT  = 16,
    parameter int DATA_W = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              pts_x_ciclo,
    input  logic [31:0]              ciclos,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     data_valid,
    input  logic signed [31:0]       ref_seno,
    input  logic signed [31:0]       ref_cos,
    output logic                     avanzar_en_tabla,
    output logic                     busy,
    output logic                     result_valid,
    output logic signed [OUT_W-1:0]  data_out_x,
    output logic signed [OUT_W-1:0]  data_out_y
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    state_t                   state_q, state_d;
    logic [ACC_W-1:0]         n_total_q, n_total_d;
    logic [ACC_W-1:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]         cnt_inc;
    logic [ACC_W-1:0]         n_start;
    logic [DRAIN_W-1:0]       drain_q, drain_d;
    logic signed [DATA_W-1:0] s1_q, s1_d;
    logic                     s1_valid_q, s1_valid_d;
    logic                     accept;
    logic                     clr;

    logic signed [31:0]       ref_lane  [2];
    logic signed [ACC_W-1:0]  acc_lane  [2];
    logic signed [OUT_W-1:0]  data_lane [2];

    assign n_start = ACC_W'(pts_x_ciclo) * ACC_W'(ciclos);
    assign cnt_inc = cnt_q + ACC_W'(1);
    assign accept  = (state_q == ACUM) && data_valid;
    assign clr     = (state_q == IDLE) && start;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (n_start == '0) ? DRAIN : ACUM;
            ACUM:    if (data_valid && (cnt_inc == n_total_q)) state_d = DRAIN;
            DRAIN:   if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        avanzar_en_tabla = accept;
        busy             = (state_q != IDLE);
        result_valid     = (state_q == DONE);
    end

    // Run bookkeeping: sample count, drain timer and the stage-0 sample register.
    always_comb begin
        n_total_d  = n_total_q;
        cnt_d      = cnt_q;
        drain_d    = '0;
        s1_d       = s1_q;
        s1_valid_d = accept;
        if (clr) begin
            n_total_d = n_start;
            cnt_d     = '0;
        end else if (accept) begin
            cnt_d = cnt_inc;
            s1_d  = data_in;
        end
        if (state_q == DRAIN) begin
            drain_d = drain_q + DRAIN_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            n_total_q  <= '0;
            cnt_q      <= '0;
            drain_q    <= '0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            n_total_q  <= n_total_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    assign ref_lane[0] = ref_seno;
    assign ref_lane[1] = ref_cos;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [ACC_W-1:0] shifted;
            logic signed [OUT_W-1:0] res;
            logic signed [OUT_W-1:0] out_q, out_d;

            mac_lockin #(
                .DATA_W (DATA_W),
                .REF_W  (32)
            ) u_mac (
                .clock    (clock),
                .reset    (reset),
                .clr_i    (clr),
                .en_i     (s1_valid_q),
                .sample_i (s1_q),
                .ref_i    (ref_lane[gi]),
                .acc_o    (acc_lane[gi])
            );

            assign shifted = acc_lane[gi] >>> SHIFT;
`ifdef LOCKIN_SAT_EN
            assign res = saturate_out(shifted);
`else
            assign res = shifted[OUT_W-1:0];
`endif
            // Result shows combinationally in DONE and is held from then on.
            assign out_d         = (state_q == DONE) ? res : out_q;
            assign data_lane[gi] = out_d;

            always_ff @(posedge clock) begin
                if (reset) begin
                    out_q <= '0;
                end else begin
                    out_q <= out_d;
                end
            end
        end
    endgenerate

    assign data_out_x = data_lane[0];
    assign data_out_y = data_lane[1];

endmodule

// File: tb/tb_demodulador_lockin.sv
// Self-checking bench for demodulador_lockin: reference table model, run-level
// sum model and a per-cycle compare process.
`timescale 1ns/1ps
module tb_demodulador_lockin;

    localparam int SHIFT_TB = 0;
    localparam int DW       = 16;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [31:0]          pts_x_ciclo;
    logic [31:0]          ciclos;
    logic signed [DW-1:0] data_in;
    logic                 data_valid;
    logic signed [31:0]   ref_seno;
    logic signed [31:0]   ref_cos;
    logic                 avanzar_en_tabla;
    logic                 busy;
    logic                 result_valid;
    logic signed [31:0]   data_out_x;
    logic signed [31:0]   data_out_y;

    demodulador_lockin #(.SHIFT(SHIFT_TB), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .pts_x_ciclo      (pts_x_ciclo),
        .ciclos           (ciclos),
        .data_in          (data_in),
        .data_valid       (data_valid),
        .ref_seno         (ref_seno),
        .ref_cos          (ref_cos),
        .avanzar_en_tabla (avanzar_en_tabla),
        .busy             (busy),
        .result_valid     (result_valid),
        .data_out_x       (data_out_x),
        .data_out_y       (data_out_y)
    );

    always #5 clock = ~clock;

    // Reference table: advances on the strobe, value valid the following cycle.
    int tab_s [4];
    int tab_c [4];
    int amp   [4];
    int ptr = 0;
    always @(posedge clock) begin
        if (avanzar_en_tabla) begin
            ref_seno <= tab_s[ptr];
            ref_cos  <= tab_c[ptr];
            ptr      <= (ptr + 1) % 4;
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    bit                 chk_en   = 0;
    int                 busy_lo  = -10;
    int                 busy_hi  = -10;
    int                 rv_cyc   = -10;
    int                 clr_cyc  = -10;
    logic               exp_adv  = 1'b0;
    logic signed [31:0] exp_x    = 0;
    logic signed [31:0] exp_y    = 0;
    logic signed [31:0] hold_x   = 0;
    logic signed [31:0] hold_y   = 0;
    logic signed [31:0] lit_x    = 0;
    logic signed [31:0] lit_y    = 0;
    bit                 lit_en   = 0;
    int                 exp_acc_cnt = 0;
    int                 adv_cnt  = 0;

    function automatic logic signed [31:0] reduce(input longint acc);
        longint sh;
        sh = acc >>> SHIFT_TB;
`ifdef LOCKIN_SAT_EN
        if (sh > 64'sd2147483647) return 32'sh7FFF_FFFF;
        if (sh < -64'sd2147483648) return 32'sh8000_0000;
`endif
        return sh[31:0];
    endfunction

    function automatic logic signed [15:0] sample(input int mode, input int p);
        case (mode)
            0:       return 16'sd1000;
            1:       return 16'(amp[p]);
            default: return 16'sh8000;
        endcase
    endfunction

    task automatic check1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, req);
        end
    endtask

    task automatic check32(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (chk_en) begin
            if (cyc == clr_cyc) begin
                hold_x = 0;
                hold_y = 0;
            end
            if (cyc == busy_lo) adv_cnt = 0;
            if (avanzar_en_tabla === 1'b1) adv_cnt++;
            check1("avanzar", avanzar_en_tabla, exp_adv);
            check1("busy", busy, (cyc > busy_lo) && (cyc <= busy_hi));
            check1("result_valid", result_valid, cyc == rv_cyc);
            if (cyc == rv_cyc) begin
                check32("x_model", data_out_x, exp_x);
                check32("y_model", data_out_y, exp_y);
                check32("adv_count", adv_cnt, exp_acc_cnt);
                if (lit_en) begin
                    check32("x_literal", data_out_x, lit_x);
                    check32("y_literal", data_out_y, lit_y);
                end
                hold_x = exp_x;
                hold_y = exp_y;
            end else begin
                check32("x_hold", data_out_x, hold_x);
                check32("y_hold", data_out_y, hold_y);
            end
        end
    end

    task automatic run(input string name, input int pts, input int cic, input int mode,
                       input bit gaps, input int abort_after, input bit lit,
                       input logic signed [31:0] lx, input logic signed [31:0] ly);
        longint n;
        longint sx;
        longint sy;
        int     k;
        int     v;
        n  = longint'(pts) * longint'(cic);
        sx = 0;
        sy = 0;
        k  = 0;
        @(posedge clock); #1;
        start       = 1'b1;
        pts_x_ciclo = pts;
        ciclos      = cic;
        data_valid  = 1'b0;
        exp_adv     = 1'b0;
        busy_lo     = cyc;
        busy_hi     = 1 << 30;
        rv_cyc      = -10;
        lit_en      = lit;
        lit_x       = lx;
        lit_y       = ly;
        if (n == 0) begin
            rv_cyc      = cyc + 3;
            busy_hi     = cyc + 3;
            exp_x       = reduce(0);
            exp_y       = reduce(0);
            exp_acc_cnt = 0;
        end
        @(posedge clock); #1;
        start = 1'b0;
        while (longint'(k) < n) begin
            if (abort_after >= 0 && k == abort_after) begin
                reset      = 1'b1;
                data_valid = 1'b0;
                exp_adv    = 1'b0;
                busy_hi    = cyc;
                clr_cyc    = cyc + 1;
                @(posedge clock); #1;
                reset = 1'b0;
                $display("run %s: aborted by reset after %0d samples", name, k);
                return;
            end
            v          = gaps ? int'($urandom_range(0, 1)) : 1;
            data_valid = v[0];
            exp_adv    = v[0];
            data_in    = sample(mode, ptr);
            if (v[0]) begin
                sx += longint'(data_in) * longint'(tab_s[ptr]);
                sy += longint'(data_in) * longint'(tab_c[ptr]);
                k++;
                if (longint'(k) == n) begin
                    rv_cyc      = cyc + 3;
                    busy_hi     = cyc + 3;
                    exp_x       = reduce(sx);
                    exp_y       = reduce(sy);
                    exp_acc_cnt = k;
                end
            end
            @(posedge clock); #1;
        end
        // Stray start and data_valid after acceptance ends must be ignored.
        start      = 1'b1;
        data_valid = 1'b1;
        exp_adv    = 1'b0;
        @(posedge clock); #1;
        start = 1'b0;
        while (cyc <= rv_cyc) begin
            @(posedge clock); #1;
        end
        data_valid = 1'b0;
        $display("run %s: samples=%0d x=%0d y=%0d expected x=%0d y=%0d",
                 name, k, data_out_x, data_out_y, exp_x, exp_y);
    endtask

    initial begin
        logic signed [31:0] sat_lit;
        reset       = 1'b1;
        start       = 1'b0;
        data_valid  = 1'b0;
        data_in     = '0;
        pts_x_ciclo = '0;
        ciclos      = '0;
        for (int i = 0; i < 4; i++) begin
            tab_s[i] = 2;
            tab_c[i] = 2;
        end
        amp[0] = 0;
        amp[1] = 100;
        amp[2] = 0;
        amp[3] = -100;
        @(posedge clock); #1;
        chk_en = 1;
        @(posedge clock); #1;
        reset = 1'b0;

        run("basic", 4, 2, 0, 0, -1, 1, 32'sd16000, 32'sd16000);

        tab_s[0] = 0;      tab_s[1] = 32767; tab_s[2] = 0;      tab_s[3] = -32767;
        tab_c[0] = 32767;  tab_c[1] = 0;     tab_c[2] = -32767; tab_c[3] = 0;
        run("sine", 4, 10, 1, 0, -1, 1, 32'sd65534000, 32'sd0);
        run("sine_gaps", 4, 10, 1, 1, -1, 1, 32'sd65534000, 32'sd0);

        run("zero_cycles", 4, 0, 0, 0, -1, 1, 32'sd0, 32'sd0);

        for (int i = 0; i < 4; i++) begin
            tab_s[i] = 2;
            tab_c[i] = 2;
        end
        run("abort", 4, 2, 0, 0, 3, 0, 32'sd0, 32'sd0);
        repeat (2) begin
            @(posedge clock); #1;
        end
        run("after_abort", 4, 2, 0, 0, -1, 1, 32'sd16000, 32'sd16000);

        for (int i = 0; i < 4; i++) begin
            tab_s[i] = 32767;
            tab_c[i] = 32767;
        end
`ifdef LOCKIN_SAT_EN
        sat_lit = 32'sh8000_0000;
`else
        sat_lit = 32'sd131072;
`endif
        run("overflow", 4, 1, 2, 0, -1, 1, sat_lit, sat_lit);

        repeat (3) begin
            @(posedge clock); #1;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
